// File: rtl/lat_tester_ctrl.sv
// Display latency measurement controller: waits for a dark screen, lights the
// test patch on a frame boundary and times the photodiode response in microseconds.
module lat_tester_ctrl #(
  parameter int unsigned PRESCALE     = 27,
  parameter int unsigned DARK_FRAMES  = 3,
  parameter logic [7:0]  DARK_TIMEOUT = 8'd120,
  parameter int unsigned SENSOR_FILT  = 16,
  parameter logic [15:0] MAX_US       = 16'd65000
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode_in,
  input  logic        VSYNC_in,
  input  logic        sensor_in,
  output logic        lt_active,
  output logic [1:0]  lt_mode,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err_dark,
  output logic        err_timeout
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FW = $clog2(SENSOR_FILT + 1);
  localparam int unsigned DW = $clog2(DARK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(SENSOR_FILT);
  localparam logic [DW-1:0] DARK_REQ   = DW'(DARK_FRAMES);
  localparam logic [15:0]   US_LAST    = MAX_US - 16'd1;

  typedef enum logic [1:0] {IDLE, WAIT_DARK, MEASURE, HOLD} state_t;

  state_t        state, state_nxt;
  logic          sens_meta, sens_s, vs_q;
  logic [FW-1:0] filt_cnt;
  logic [DW-1:0] dark_cnt, dark_nxt, dark_inc;
  logic [7:0]    frame_cnt, frame_nxt, frame_inc;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   us_cnt, us_nxt, result_nxt;
  logic [1:0]    mode_nxt;
  logic          active_nxt, valid_nxt, err_dark_nxt, err_to_nxt, busy_nxt;
  logic          lit, vs_fall, tick;

  // Sensor synchronizer, glitch filter and VSYNC edge register
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sens_meta <= 1'b0;
      sens_s    <= 1'b0;
      filt_cnt  <= '0;
      vs_q      <= 1'b0;
    end else begin
      sens_meta <= sensor_in;
      sens_s    <= sens_meta;
      vs_q      <= VSYNC_in;
      if (!sens_s)
        filt_cnt <= '0;
      else if (filt_cnt != FILT_MAX)
        filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign lit       = (filt_cnt == FILT_MAX);
  assign vs_fall   = vs_q & ~VSYNC_in;
  assign tick      = (presc == PRESC_LAST);
  assign dark_inc  = dark_cnt + DW'(1);
  assign frame_inc = frame_cnt + 8'd1;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    active_nxt   = lt_active;
    mode_nxt     = lt_mode;
    result_nxt   = result;
    valid_nxt    = result_valid;
    err_dark_nxt = err_dark;
    err_to_nxt   = err_timeout;
    dark_nxt     = dark_cnt;
    frame_nxt    = frame_cnt;
    presc_nxt    = presc;
    us_nxt       = us_cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          mode_nxt     = mode_in;
          valid_nxt    = 1'b0;
          err_dark_nxt = 1'b0;
          err_to_nxt   = 1'b0;
          dark_nxt     = '0;
          frame_nxt    = '0;
          state_nxt    = WAIT_DARK;
        end
      end
      WAIT_DARK: begin
        if (vs_fall) begin
          frame_nxt = frame_inc;
          dark_nxt  = sens_s ? '0 : dark_inc;
          if (!sens_s && dark_inc == DARK_REQ) begin
            state_nxt  = MEASURE;
            active_nxt = 1'b1;
            presc_nxt  = '0;
            us_nxt     = '0;
          end else if (frame_inc == DARK_TIMEOUT) begin
            err_dark_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end
      end
      MEASURE: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) us_nxt = us_cnt + 16'd1;
        if (lit) begin
          result_nxt = us_cnt;
          valid_nxt  = 1'b1;
          state_nxt  = HOLD;
        end else if (tick && us_cnt == US_LAST) begin
          result_nxt = 16'hFFFF;
          err_to_nxt = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        // Patch is only removed at a frame boundary
        if (vs_fall) begin
          active_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt    = IDLE;
      active_nxt   = 1'b0;
      result_nxt   = result;
      valid_nxt    = result_valid;
      err_dark_nxt = err_dark;
      err_to_nxt   = err_timeout;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      lt_active    <= 1'b0;
      lt_mode      <= 2'b00;
      busy         <= 1'b0;
      result       <= 16'd0;
      result_valid <= 1'b0;
      err_dark     <= 1'b0;
      err_timeout  <= 1'b0;
      dark_cnt     <= '0;
      frame_cnt    <= '0;
      presc        <= '0;
      us_cnt       <= '0;
    end else begin
      lt_active    <= active_nxt;
      lt_mode      <= mode_nxt;
      busy         <= busy_nxt;
      result       <= result_nxt;
      result_valid <= valid_nxt;
      err_dark     <= err_dark_nxt;
      err_timeout  <= err_to_nxt;
      dark_cnt     <= dark_nxt;
      frame_cnt    <= frame_nxt;
      presc        <= presc_nxt;
      us_cnt       <= us_nxt;
    end
  end

endmodule

// File: tb/tb_lat_tester_ctrl.sv
// Randomized bench for lat_tester_ctrl with shortened timing parameters; expected
// latencies are derived from the stimulus timeline (frame edges, sensor rise times).
module tb_lat_tester_ctrl;

  localparam int P    = 5;
  localparam int DF   = 3;
  localparam int DT   = 10;
  localparam int F    = 6;
  localparam int MAXU = 40;
  localparam int FP   = 40;
  localparam int VLOW = 4;

  logic        clk27 = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode_in = 2'b00;
  logic        VSYNC_in = 1'b1;
  logic        sensor_in = 1'b0;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
  logic        err_dark;
  logic        err_timeout;

  lat_tester_ctrl #(
    .PRESCALE(P), .DARK_FRAMES(DF), .DARK_TIMEOUT(8'(DT)),
    .SENSOR_FILT(F), .MAX_US(16'(MAXU))
  ) dut (
    .clk27(clk27), .reset_n(reset_n), .start(start), .abort(abort),
    .mode_in(mode_in), .VSYNC_in(VSYNC_in), .sensor_in(sensor_in),
    .lt_active(lt_active), .lt_mode(lt_mode), .busy(busy), .result(result),
    .result_valid(result_valid), .err_dark(err_dark), .err_timeout(err_timeout)
  );

  always #5 clk27 = ~clk27;

  int n_pass = 0;
  int n_checks = 0;
  int exp_last_result = 0;

  // Posedge timeline: cycle index and every VSYNC falling edge sampled there
  int cyc = 0;
  int nfall = 0;
  int fall_cyc[$];
  bit vs_prev = 1'b0;
  always @(posedge clk27) begin
    cyc++;
    if (vs_prev && !VSYNC_in) begin
      nfall++;
      fall_cyc.push_back(cyc);
    end
    vs_prev = VSYNC_in;
  end

  // Free-running frame generator: FP cycles per frame, VSYNC low for VLOW
  int vphase = 0;
  always @(negedge clk27) begin
    VSYNC_in = (vphase >= VLOW);
    vphase = (vphase + 1) % FP;
  end

  // Output edge capture, recorded as the posedge index that produced it
  int la_rise_cyc = -1, la_fall_cyc = -1, rv_rise_cyc = -1;
  int et_rise_cyc = -1, ed_rise_cyc = -1, la_rise_n = 0;
  logic la_p = 1'b0, rv_p = 1'b0, et_p = 1'b0, ed_p = 1'b0;
  always @(negedge clk27) begin
    if (lt_active && !la_p) begin la_rise_cyc = cyc; la_rise_n++; end
    if (!lt_active && la_p) la_fall_cyc = cyc;
    if (result_valid && !rv_p) rv_rise_cyc = cyc;
    if (err_timeout && !et_p) et_rise_cyc = cyc;
    if (err_dark && !ed_p) ed_rise_cyc = cyc;
    la_p = lt_active; rv_p = result_valid; et_p = err_timeout; ed_p = err_dark;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk27); #1; end
  endtask

  function automatic int nth_fall_after(input int c, input int n);
    int k = 0;
    foreach (fall_cyc[i]) if (fall_cyc[i] > c) begin
      k++;
      if (k == n) return fall_cyc[i];
    end
    return -1;
  endfunction

  task automatic wait_falls(input int n);
    int target = nfall + n;
    bit ok = 1'b0;
    for (int i = 0; i < FP * (n + 2); i++) begin
      tick(1);
      if (nfall >= target) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_checks++; $display("FAIL wait_falls: got no frame edge, want %0d", n); end
  endtask

  task automatic wait_active();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (lt_active === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    if (!ok) begin n_checks++; $display("FAIL wait_active: got lt_active=%b want 1", lt_active); end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      tick(1);
    end
    if (!ok) begin n_checks++; $display("FAIL wait_idle: got busy=%b want 0", busy); end
  endtask

  // Align to mid-frame, set sensor level and issue start; sc = posedge that samples start
  task automatic begin_meas(input logic [1:0] m, input logic sens, output int sc);
    wait_falls(1);
    tick(10);
    sensor_in = sens;
    mode_in = m;
    start = 1'b1;
    sc = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(3);
    n_checks++; if (lt_active !== 1'b0) $display("FAIL reset_lt_active: got %b want 0", lt_active); else n_pass++;
    n_checks++; if (lt_mode !== 2'b00) $display("FAIL reset_lt_mode: got %b want 00", lt_mode); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== 16'd0) $display("FAIL reset_result: got %0d want 0", result); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++; if (err_dark !== 1'b0) $display("FAIL reset_err_dark: got %b want 0", err_dark); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err_timeout: got %b want 0", err_timeout); else n_pass++;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [1:0] m = 2'($urandom_range(0, 3));
      int d = int'($urandom_range(0, 150));
      int sc, fexp, k0, lexp, rexp;
      begin_meas(m, 1'b0, sc);
      wait_active();
      fexp = nth_fall_after(sc, DF);
      n_checks++; if (la_rise_cyc !== fexp) $display("FAIL basic_rise: got cycle %0d want %0d", la_rise_cyc, fexp); else n_pass++;
      n_checks++; if (lt_mode !== m) $display("FAIL basic_mode: got %b want %b", lt_mode, m); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      tick(d);
      sensor_in = 1'b1;
      k0 = cyc + 1;
      lexp = k0 + F + 2;
      rexp = (k0 + F + 1 - fexp) / P;
      wait_idle();
      n_checks++; if (rv_rise_cyc !== lexp) $display("FAIL basic_done_cycle: got %0d want %0d", rv_rise_cyc, lexp); else n_pass++;
      n_checks++; if (result !== 16'(rexp)) $display("FAIL basic_result: got %0d want %0d", result, rexp); else n_pass++;
      n_checks++; if (result_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", result_valid); else n_pass++;
      n_checks++; if (err_timeout !== 1'b0 || err_dark !== 1'b0) $display("FAIL basic_errs: got %b%b want 00", err_dark, err_timeout); else n_pass++;
      n_checks++; if (la_fall_cyc !== nth_fall_after(lexp, 1)) $display("FAIL basic_patch_off: got %0d want %0d", la_fall_cyc, nth_fall_after(lexp, 1)); else n_pass++;
      exp_last_result = rexp;
    end
  endtask

  task automatic test_dark_retry();
    for (int it = 0; it < 2; it++) begin
      int b = (it == 0) ? 2 : int'($urandom_range(0, 4));
      int sc, fexp;
      la_rise_n = 0;
      begin_meas(2'b10, b >= 1, sc);
      for (int n = 1; n <= b + 2; n++) begin
        wait_falls(1);
        tick(10);
        sensor_in = (n + 1 <= b);
      end
      wait_active();
      fexp = nth_fall_after(sc, b + DF);
      n_checks++; if (la_rise_cyc !== fexp) $display("FAIL retry_rise: got %0d want %0d (bright=%0d)", la_rise_cyc, fexp, b); else n_pass++;
      n_checks++; if (la_rise_n !== 1) $display("FAIL retry_rise_count: got %0d want 1", la_rise_n); else n_pass++;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL retry_abort_busy: got %b want 0", busy); else n_pass++;
    end
  endtask

  task automatic test_dark_error();
    int sc, fexp;
    la_rise_n = 0;
    ed_rise_cyc = -1;
    begin_meas(2'b01, 1'b1, sc);
    wait_idle();
    fexp = nth_fall_after(sc, DT);
    n_checks++; if (ed_rise_cyc !== fexp) $display("FAIL dark_err_cycle: got %0d want %0d", ed_rise_cyc, fexp); else n_pass++;
    n_checks++; if (err_dark !== 1'b1) $display("FAIL dark_err_flag: got %b want 1", err_dark); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL dark_err_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (la_rise_n !== 0) $display("FAIL dark_err_patch: got %0d rises want 0", la_rise_n); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL dark_err_valid: got %b want 0", result_valid); else n_pass++;
  endtask

  task automatic test_timeout();
    int sc, fexp, texp;
    et_rise_cyc = -1;
    begin_meas(2'b11, 1'b0, sc);
    wait_active();
    fexp = nth_fall_after(sc, DF);
    texp = fexp + MAXU * P;
    wait_idle();
    n_checks++; if (et_rise_cyc !== texp) $display("FAIL timeout_cycle: got %0d want %0d", et_rise_cyc, texp); else n_pass++;
    n_checks++; if (result !== 16'hFFFF) $display("FAIL timeout_result: got %h want ffff", result); else n_pass++;
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_flag: got %b want 1", err_timeout); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL timeout_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++; if (la_fall_cyc !== nth_fall_after(texp, 1)) $display("FAIL timeout_patch_off: got %0d want %0d", la_fall_cyc, nth_fall_after(texp, 1)); else n_pass++;
    exp_last_result = 16'hFFFF;
  endtask

  task automatic test_glitch();
    for (int it = 0; it < 3; it++) begin
      int sc, fexp, k0, rexp;
      int g = int'($urandom_range(1, F - 1));
      begin_meas(2'b01, 1'b0, sc);
      wait_active();
      fexp = nth_fall_after(sc, DF);
      tick(int'($urandom_range(0, 30)));
      sensor_in = 1'b1;
      tick(g);
      sensor_in = 1'b0;
      tick(int'($urandom_range(1, 20)));
      sensor_in = 1'b1;
      k0 = cyc + 1;
      rexp = (k0 + F + 1 - fexp) / P;
      wait_idle();
      n_checks++; if (result !== 16'(rexp)) $display("FAIL glitch_result: got %0d want %0d (glitch %0d)", result, rexp, g); else n_pass++;
      n_checks++; if (rv_rise_cyc !== k0 + F + 2) $display("FAIL glitch_done_cycle: got %0d want %0d", rv_rise_cyc, k0 + F + 2); else n_pass++;
      exp_last_result = rexp;
    end
  endtask

  task automatic test_abort();
    logic [1:0] m1 = 2'($urandom_range(0, 3));
    logic [1:0] m2 = m1 ^ 2'b11;
    int sc;
    begin_meas(m1, 1'b0, sc);
    wait_active();
    tick(int'($urandom_range(2, 40)));
    mode_in = m2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_checks++; if (lt_mode !== m1) $display("FAIL busy_start_mode: got %b want %b", lt_mode, m1); else n_pass++;
    n_checks++; if (busy !== 1'b1 || lt_active !== 1'b1) $display("FAIL busy_start_state: got busy=%b act=%b want 1 1", busy, lt_active); else n_pass++;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_checks++; if (lt_active !== 1'b0) $display("FAIL abort_active: got %b want 0", lt_active); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++; if (result !== 16'(exp_last_result)) $display("FAIL abort_result: got %0d want %0d", result, exp_last_result); else n_pass++;
    mode_in = m2;
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_start_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (lt_mode !== m1) $display("FAIL abort_start_mode: got %b want %b", lt_mode, m1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] m = 2'($urandom_range(1, 3));
    int sc;
    begin_meas(m, 1'b0, sc);
    wait_active();
    tick(int'($urandom_range(3, 30)));
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (lt_active !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_act_busy: got %b %b want 0 0", lt_active, busy); else n_pass++;
    n_checks++; if (lt_mode !== 2'b00) $display("FAIL midreset_mode: got %b want 00", lt_mode); else n_pass++;
    n_checks++; if (result !== 16'd0) $display("FAIL midreset_result: got %0d want 0", result); else n_pass++;
    n_checks++; if (result_valid !== 1'b0 || err_dark !== 1'b0 || err_timeout !== 1'b0) $display("FAIL midreset_flags: got %b%b%b want 000", result_valid, err_dark, err_timeout); else n_pass++;
    tick(2);
    reset_n = 1'b1;
    exp_last_result = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_basic(4);
    test_dark_retry();
    test_dark_error();
    test_timeout();
    test_glitch();
    test_abort();
    test_reset_mid();
    test_basic(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
